// File: rtl/neuron_accumulator.sv
// Floating-point (1/6/12) accumulator feeding the sigmoid stage: sums TERMS products per neuron.
// Optional macro NEURON_BIAS_EN adds Bias* inputs that seed the accumulator instead of zero.
module neuron_accumulator #(
  parameter int unsigned TERMS = 4
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        TermValid,
  output logic        TermReady,
  input  logic        TermSign,
  input  logic [5:0]  TermExponent,
  input  logic [11:0] TermMantissa,
`ifdef NEURON_BIAS_EN
  input  logic        BiasSign,
  input  logic [5:0]  BiasExponent,
  input  logic [11:0] BiasMantissa,
`endif
  output logic        SumSign,
  output logic [5:0]  SumExponent,
  output logic [11:0] SumMantissa,
  output logic        SumValid
);

  typedef enum logic [2:0] {ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM, ST_DONE} state_t;

  typedef struct packed {
    logic        sign;
    logic [5:0]  exp;
    logic [11:0] man;
  } fp_t;

  localparam logic [7:0] TERMS_CNT = 8'(TERMS);

  state_t      state, state_next;
  fp_t         term, acc, sum, acc_init, norm;
  logic [7:0]  cnt, cnt_inc;
  logic        sum_valid;

  // Pipeline registers between ALIGN, ADD and NORM
  logic        big_sign, sub_op, res_sign;
  logic [5:0]  big_exp, res_exp;
  logic [12:0] big_sig, small_sig;
  logic [13:0] sum_raw;

`ifdef NEURON_BIAS_EN
  assign acc_init = '{sign: BiasSign, exp: BiasExponent, man: BiasMantissa};
`else
  assign acc_init = '0;
`endif

  assign cnt_inc = cnt + 8'd1;

  function automatic logic [3:0] lead_zeros(input logic [12:0] v);
    lead_zeros = 4'd13;
    for (int i = 0; i <= 12; i++) begin
      if (v[i]) lead_zeros = 4'(12 - i);
    end
  endfunction

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    TermReady  = 1'b0;
    case (state)
      ST_IDLE: begin
        TermReady = 1'b1;
        if (TermValid) state_next = ST_ALIGN;
      end
      ST_ALIGN: state_next = ST_ADD;
      ST_ADD:   state_next = ST_NORM;
      ST_NORM:  state_next = (cnt_inc == TERMS_CNT) ? ST_DONE : ST_IDLE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Alignment: a zero operand (exponent 0) contributes a zero significand.
  logic        acc_ge;
  fp_t         op_big, op_small;
  logic [12:0] op_big_sig, op_small_sig, op_small_sh;
  logic [5:0]  exp_diff;

  always_comb begin
    acc_ge       = {acc.exp, acc.man} >= {term.exp, term.man};
    op_big       = acc_ge ? acc : term;
    op_small     = acc_ge ? term : acc;
    op_big_sig   = (op_big.exp == 6'd0) ? 13'd0 : {1'b1, op_big.man};
    op_small_sig = (op_small.exp == 6'd0) ? 13'd0 : {1'b1, op_small.man};
    exp_diff     = op_big.exp - op_small.exp;
    op_small_sh  = (exp_diff >= 6'd13) ? 13'd0 : (op_small_sig >> exp_diff);
  end

  // Normalisation with truncation, underflow to canonical zero and saturation on overflow.
  logic [3:0]         lzc;
  logic signed [7:0]  norm_exp;
  logic [11:0]        norm_man;

  always_comb begin
    lzc  = lead_zeros(sum_raw[12:0]);
    norm = '0;
    if (sum_raw[13]) begin
      norm_exp = $signed({2'b00, res_exp}) + 8'sd1;
      norm_man = sum_raw[12:1];
    end else begin
      norm_exp = $signed({2'b00, res_exp}) - $signed({4'b0000, lzc});
      norm_man = sum_raw[11:0] << lzc;
    end
    if (sum_raw == 14'd0 || norm_exp < 8'sd1) begin
      norm = '0;
    end else if (norm_exp > 8'sd63) begin
      norm = '{sign: res_sign, exp: 6'd63, man: 12'hfff};
    end else begin
      norm = '{sign: res_sign, exp: norm_exp[5:0], man: norm_man};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state     <= ST_IDLE;
      acc       <= acc_init;
      cnt       <= 8'd0;
      sum       <= '0;
      sum_valid <= 1'b0;
      term      <= '0;
      big_sign  <= 1'b0;
      sub_op    <= 1'b0;
      big_exp   <= 6'd0;
      big_sig   <= 13'd0;
      small_sig <= 13'd0;
      res_sign  <= 1'b0;
      res_exp   <= 6'd0;
      sum_raw   <= 14'd0;
    end else begin
      state     <= state_next;
      sum_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (TermValid) term <= '{sign: TermSign, exp: TermExponent, man: TermMantissa};
        end
        ST_ALIGN: begin
          big_sign  <= op_big.sign;
          big_exp   <= op_big.exp;
          big_sig   <= op_big_sig;
          small_sig <= op_small_sh;
          sub_op    <= acc.sign ^ term.sign;
        end
        ST_ADD: begin
          res_sign <= big_sign;
          res_exp  <= big_exp;
          sum_raw  <= sub_op ? ({1'b0, big_sig} - {1'b0, small_sig})
                             : ({1'b0, big_sig} + {1'b0, small_sig});
        end
        ST_NORM: begin
          acc <= norm;
          cnt <= cnt_inc;
        end
        ST_DONE: begin
          sum       <= acc;
          sum_valid <= 1'b1;
          acc       <= acc_init;
          cnt       <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  assign SumSign     = sum.sign;
  assign SumExponent = sum.exp;
  assign SumMantissa = sum.man;
  assign SumValid    = sum_valid;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: directed cases plus random neurons
// checked against an integer-arithmetic model of the float sum.
module tb_neuron_accumulator;

  localparam int TERMS = 4;
  localparam logic [18:0] ONE = {1'b0, 6'd31, 12'h000};

`ifdef NEURON_BIAS_EN
  localparam logic [18:0] BIAS       = {1'b1, 6'd31, 12'h000};
  localparam logic [18:0] EXP_ONES   = {1'b0, 6'd32, 12'h800};
  localparam logic [18:0] EXP_CANCEL = {1'b1, 6'd30, 12'h000};
  localparam logic [18:0] EXP_TINY   = {1'b0, 6'd17, 12'h000};
`else
  localparam logic [18:0] BIAS       = 19'd0;
  localparam logic [18:0] EXP_ONES   = {1'b0, 6'd33, 12'h000};
  localparam logic [18:0] EXP_CANCEL = {1'b0, 6'd30, 12'h000};
  localparam logic [18:0] EXP_TINY   = {1'b0, 6'd31, 12'h000};
`endif
  localparam logic [18:0] EXP_SAT    = {1'b0, 6'd63, 12'hfff};

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        TermValid = 1'b0;
  logic        TermReady;
  logic        TermSign = 1'b0;
  logic [5:0]  TermExponent = 6'd0;
  logic [11:0] TermMantissa = 12'd0;
  logic        SumSign;
  logic [5:0]  SumExponent;
  logic [11:0] SumMantissa;
  logic        SumValid;
  logic [18:0] bias_val = BIAS;

  neuron_accumulator #(.TERMS(TERMS)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .TermValid    (TermValid),
    .TermReady    (TermReady),
    .TermSign     (TermSign),
    .TermExponent (TermExponent),
    .TermMantissa (TermMantissa),
`ifdef NEURON_BIAS_EN
    .BiasSign     (bias_val[18]),
    .BiasExponent (bias_val[17:12]),
    .BiasMantissa (bias_val[11:0]),
`endif
    .SumSign      (SumSign),
    .SumExponent  (SumExponent),
    .SumMantissa  (SumMantissa),
    .SumValid     (SumValid)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [18:0] model_acc;
  logic [18:0] got_q[$];
  int          got_cyc[$];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) begin
    #1;
    if (SumValid) begin
      got_q.push_back({SumSign, SumExponent, SumMantissa});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer sum of significands after truncated alignment,
  // then renormalise by repeated halving/doubling.
  function automatic logic [18:0] ref_add(input logic [18:0] a, input logic [18:0] b);
    int ea = int'(a[17:12]);
    int eb = int'(b[17:12]);
    int ma = (ea == 0) ? 0 : 4096 + int'(a[11:0]);
    int mb = (eb == 0) ? 0 : 4096 + int'(b[11:0]);
    int e, hi, lo, sh, r;
    logic s;
    if (ea * 8192 + ma >= eb * 8192 + mb) begin
      e = ea; hi = ma; lo = mb; sh = ea - eb; s = a[18];
    end else begin
      e = eb; hi = mb; lo = ma; sh = eb - ea; s = b[18];
    end
    lo = (sh >= 13) ? 0 : lo / (1 << sh);
    r  = (a[18] == b[18]) ? hi + lo : hi - lo;
    if (r == 0) return 19'd0;
    while (r >= 8192) begin r = r / 2; e++; end
    while (r < 4096) begin r = r * 2; e--; end
    if (e < 1) return 19'd0;
    if (e > 63) return {s, 6'd63, 12'hfff};
    return {s, 6'(e), 12'(r - 4096)};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [18:0] t);
    int guard = 0;
    @(negedge Clock);
    {TermSign, TermExponent, TermMantissa} = t;
    TermValid = 1'b1;
    while (!TermReady && guard < 40) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= 40) check("ready_timeout", 32'(TermReady), 32'd1);
    @(posedge Clock);
    #1;
    TermValid = 1'b0;
    last_acc  = cyc;
    model_acc = ref_add(model_acc, t);
  endtask

  // Sum* appear 4 edges after the last accept; strobe must last one cycle and values must hold.
  task automatic expect_sum(input string tag, input logic [18:0] exp_sum, output int seen_cyc);
    int guard = 0;
    logic [18:0] v;
    seen_cyc = -1;
    while (got_q.size() == 0 && guard < 60) begin
      @(negedge Clock);
      guard++;
    end
    check({tag, "_strobes"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      v = got_q.pop_front();
      seen_cyc = got_cyc.pop_front();
      check({tag, "_sum"}, 32'(v), 32'(exp_sum));
      check({tag, "_latency"}, 32'(seen_cyc), 32'(last_acc + 4));
    end
    repeat (2) @(negedge Clock);
    check({tag, "_single"}, 32'(got_q.size()), 32'd0);
    check({tag, "_hold"}, 32'({SumSign, SumExponent, SumMantissa}), 32'(exp_sum));
    got_q.delete();
    got_cyc.delete();
    model_acc = BIAS;
  endtask

  initial begin
    int first_acc;
    int seen;
    int accepts;
    logic [18:0] t;
    model_acc = BIAS;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_ready", 32'(TermReady), 32'd1);
    check("rst_valid", 32'(SumValid), 32'd0);
    check("rst_sum", 32'({SumSign, SumExponent, SumMantissa}), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;

    // Four 1.0 terms back-to-back; accept-to-strobe spans 16 edges (17-cycle neuron period)
    send(ONE);
    first_acc = last_acc;
    repeat (3) send(ONE);
    check("ones_spacing", 32'(last_acc - first_acc), 32'd12);
    expect_sum("ones", EXP_ONES, seen);
    check("ones_period", 32'(seen - first_acc), 32'd16);

    // Cancellation to a canonical zero intermediate
    send({1'b0, 6'd31, 12'h800});
    send({1'b1, 6'd31, 12'h800});
    send({1'b0, 6'd30, 12'h000});
    send(19'd0);
    expect_sum("cancel", EXP_CANCEL, seen);

    // Small term shifted out entirely
    send(ONE);
    send({1'b0, 6'd17, 12'h000});
    send(19'd0);
    send(19'd0);
    expect_sum("tiny", EXP_TINY, seen);

    // Saturation at the top of the exponent range
    repeat (4) send({1'b0, 6'd63, 12'hfff});
    expect_sum("sat", EXP_SAT, seen);

    // TermValid held high: one capture every 4 cycles, none in DONE
    accepts = 0;
    @(negedge Clock);
    {TermSign, TermExponent, TermMantissa} = ONE;
    TermValid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge Clock);
      check($sformatf("stream_ready_%0d", i), 32'(TermReady), 32'((i % 4 == 0) && (i < 16)));
      if (TermReady) begin
        accepts++;
        last_acc = cyc + 1;
        model_acc = ref_add(model_acc, ONE);
      end
    end
    TermValid = 1'b0;
    check("stream_accepts", 32'(accepts), 32'd4);
    expect_sum("stream", EXP_ONES, seen);

    // Reset during ADD of the third term discards the partial sum
    send(ONE);
    send(ONE);
    send(ONE);
    @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b0;
    @(posedge Clock);
    #1;
    check("midrst_ready", 32'(TermReady), 32'd1);
    check("midrst_valid", 32'(SumValid), 32'd0);
    check("midrst_sum", 32'({SumSign, SumExponent, SumMantissa}), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    check("midrst_nostrobe", 32'(got_q.size()), 32'd0);
    model_acc = BIAS;
    repeat (4) send(ONE);
    expect_sum("after_rst", EXP_ONES, seen);

    // Random neurons against the reference model
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < TERMS; k++) begin
        t[18] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0:       t[17:12] = 6'd0;
          1:       t[17:12] = 6'($urandom_range(58, 63));
          default: t[17:12] = 6'($urandom_range(18, 44));
        endcase
        t[11:0] = 12'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge Clock);
        send(t);
      end
      expect_sum($sformatf("rand%0d", n), model_acc, seen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
